// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: request inputs and lamp/status outputs of the phase controller.
//   master: drives req/actuated/flash, observes lamps and status (board logic, bench)
//   slave : the controller itself
interface traffic_phase_ctrl_if #(
    parameter int unsigned NUM_PHASES = 2,
    parameter int unsigned TIMER_W    = 6
);
    localparam int unsigned PW = (NUM_PHASES <= 2) ? 1 : $clog2(NUM_PHASES);

    logic [NUM_PHASES-1:0] req;
    logic                  actuated;
    logic                  flash;
    logic [NUM_PHASES-1:0] green;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] red;
    logic [PW-1:0]         active_phase;
    logic [TIMER_W-1:0]    elapsed;
    logic [NUM_PHASES-1:0] pending;
    logic                  tick;

    modport master (
        output req, actuated, flash,
        input  green, yellow, red, active_phase, elapsed, pending, tick
    );

    modport slave (
        input  req, actuated, flash,
        output green, yellow, red, active_phase, elapsed, pending, tick
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase traffic signal controller with fixed-time and
// actuated modes, flash mode and a tick prescaler.
//   CLK100MHZ : system clock
//   reset_n   : asynchronous active-low reset
//   bus       : req/actuated/flash in; green/yellow/red lamps, active_phase,
//               elapsed, pending, tick out
module traffic_phase_ctrl #(
    parameter int unsigned NUM_PHASES = 2,
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned TIMER_W    = 6,
    parameter int unsigned GREEN_MIN  = 4,
    parameter int unsigned GREEN_MAX  = 8,
    parameter int unsigned YELLOW_T   = 2,
    parameter int unsigned ALLRED_T   = 2
) (
    input  logic                CLK100MHZ,
    input  logic                reset_n,
    traffic_phase_ctrl_if.slave bus
);
    localparam int unsigned PW = (NUM_PHASES <= 2) ? 1 : $clog2(NUM_PHASES);
    localparam int unsigned CW = $clog2(TICK_DIV);

    localparam logic [CW-1:0]      TICK_END   = CW'(TICK_DIV - 1);
    localparam logic [TIMER_W-1:0] ALLRED_END = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] YELLOW_END = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] GMIN_END   = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] GMAX_END   = TIMER_W'(GREEN_MAX - 1);
    localparam logic [PW-1:0]      LAST_PH    = PW'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_FLASH  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [PW-1:0]         phase, phase_nxt, next_pick;
    logic [TIMER_W-1:0]    elapsed, elapsed_nxt;
    logic [CW-1:0]         presc, presc_nxt;
    logic [NUM_PHASES-1:0] pending, pending_nxt;
    logic                  blink, blink_nxt;
    logic                  move;
    logic                  tick_w;
    logic                  green_done;
    logic [NUM_PHASES-1:0] phase_mask;

    assign tick_w     = (presc == TICK_END);
    assign phase_mask = NUM_PHASES'(1) << phase;

    // GREEN exit: flash pre-empts; actuated needs a conflicting request
    always_comb begin
        logic other;
        logic min_ok;
        logic max_ok;
        other  = |(pending & ~phase_mask);
        min_ok = (elapsed >= GMIN_END);
        max_ok = (elapsed >= GMAX_END);
        if (bus.flash) begin
            green_done = 1'b1;
        end else if (bus.actuated) begin
            green_done = other && ((min_ok && ((bus.req & phase_mask) == '0)) || max_ok);
        end else begin
            green_done = max_ok;
        end
    end

    // Next phase to serve: circular search for a pending phase in actuated mode
    always_comb begin
        logic                  found;
        logic [NUM_PHASES-1:0] sh;
        int unsigned           idx;
        found     = 1'b0;
        sh        = '0;
        idx       = 0;
        next_pick = (phase >= LAST_PH) ? '0 : phase + PW'(1);
        if (bus.actuated) begin
            for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
                idx = (32'(phase) + k) % NUM_PHASES;
                sh  = pending >> idx;
                if (!found && sh[0]) begin
                    found     = 1'b1;
                    next_pick = PW'(idx);
                end
            end
        end
    end

    // Next-state, counters and request latch
    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        blink_nxt   = blink;
        move        = 1'b0;
        presc_nxt   = presc;
        elapsed_nxt = elapsed;
        pending_nxt = pending;

        case (state)
            S_ALLRED: begin
                if (tick_w && elapsed >= ALLRED_END) begin
                    move = 1'b1;
                    if (bus.flash) begin
                        state_nxt = S_FLASH;
                        blink_nxt = 1'b1;
                    end else begin
                        state_nxt = S_GREEN;
                        phase_nxt = next_pick;
                    end
                end
            end
            S_GREEN: begin
                if (tick_w && green_done) begin
                    move      = 1'b1;
                    state_nxt = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (tick_w && elapsed >= YELLOW_END) begin
                    move      = 1'b1;
                    state_nxt = S_ALLRED;
                end
            end
            S_FLASH: begin
                if (tick_w) begin
                    if (!bus.flash) begin
                        move      = 1'b1;
                        state_nxt = S_ALLRED;
                        phase_nxt = LAST_PH;
                    end else begin
                        blink_nxt = ~blink;
                    end
                end
            end
            default: begin
                move      = 1'b1;
                state_nxt = S_ALLRED;
            end
        endcase

        if (move) begin
            presc_nxt   = '0;
            elapsed_nxt = '0;
        end else begin
            presc_nxt = tick_w ? '0 : presc + CW'(1);
            if (tick_w && elapsed != '1) begin
                elapsed_nxt = elapsed + TIMER_W'(1);
            end
        end

        // The phase being served in GREEN does not latch its own request
        pending_nxt = pending | (bus.req & ((state == S_GREEN) ? ~phase_mask : '1));
        if (move && state_nxt == S_GREEN) begin
            pending_nxt = pending_nxt & ~(NUM_PHASES'(1) << phase_nxt);
        end
    end

    // State and datapath registers
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_ALLRED;
            phase   <= LAST_PH;
            elapsed <= '0;
            presc   <= '0;
            pending <= '0;
            blink   <= 1'b1;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            elapsed <= elapsed_nxt;
            presc   <= presc_nxt;
            pending <= pending_nxt;
            blink   <= blink_nxt;
        end
    end

    // Moore lamp decode
    always_comb begin
        bus.green  = '0;
        bus.yellow = '0;
        bus.red    = '0;
        case (state)
            S_GREEN: begin
                bus.green = phase_mask;
                bus.red   = ~phase_mask;
            end
            S_YELLOW: begin
                bus.yellow = phase_mask;
                bus.red    = ~phase_mask;
            end
            S_FLASH: begin
                bus.yellow = NUM_PHASES'(blink);
                bus.red    = blink ? ~NUM_PHASES'(1) : '0;
            end
            default: begin
                bus.red = '1;
            end
        endcase
    end

    assign bus.active_phase = phase;
    assign bus.elapsed      = elapsed;
    assign bus.pending      = pending;
    assign bus.tick         = tick_w;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: lamp-segment scoreboard bench for traffic_phase_ctrl.
// Stimulus pushes expected {lamps, duration} segments; the monitor closes a
// segment each time the lamp vector changes and compares it (duration 0 = any).
module tb_traffic_phase_ctrl;
    localparam int unsigned N   = 3;
    localparam int unsigned TD  = 4;
    localparam int unsigned TW  = 4;
    localparam int unsigned GMN = 2;
    localparam int unsigned GMX = 5;
    localparam int unsigned YT  = 2;
    localparam int unsigned ART = 1;

    localparam logic [8:0] LR    = 9'b000_000_111;
    localparam logic [8:0] LFON  = 9'b000_001_110;
    localparam logic [8:0] LFOFF = 9'b000_000_000;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    traffic_phase_ctrl_if #(.NUM_PHASES(N), .TIMER_W(TW)) bus ();

    traffic_phase_ctrl #(
        .NUM_PHASES(N), .TICK_DIV(TD), .TIMER_W(TW), .GREEN_MIN(GMN),
        .GREEN_MAX(GMX), .YELLOW_T(YT), .ALLRED_T(ART)
    ) dut (
        .CLK100MHZ(clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    typedef struct {
        logic [8:0] lamps;
        int         dur;
        string      name;
    } seg_t;

    seg_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [8:0] lamps_now;
    assign lamps_now = {bus.green, bus.yellow, bus.red};

    function automatic logic [8:0] lg(input int p);
        logic [2:0] m;
        m = 3'(1 << p);
        return {m, 3'b000, ~m};
    endfunction

    function automatic logic [8:0] ly(input int p);
        logic [2:0] m;
        m = 3'(1 << p);
        return {3'b000, m, ~m};
    endfunction

    task automatic push(input logic [8:0] l, input int d, input string nm);
        seg_t s;
        s.lamps = l;
        s.dur   = d;
        s.name  = nm;
        sb.push_back(s);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_for(input logic [8:0] want, input int max_cyc, input string nm);
        int i;
        i = 0;
        while (lamps_now !== want && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        if (lamps_now !== want) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout %s: lamps %b expected %b", nm, lamps_now, want);
        end
    endtask

    // Monitor: segment tracking and scoreboard comparison
    logic [8:0] cur_lamps = '0;
    int         cur_len   = 0;
    logic       seg_valid = 1'b0;

    task automatic close_seg();
        seg_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL segment: got %b for %0d cycles expected no segment", cur_lamps, cur_len);
        end else begin
            e = sb.pop_front();
            if (e.lamps !== cur_lamps || (e.dur != 0 && e.dur != cur_len)) begin
                n_fail++;
                $display("FAIL segment %s: got %b for %0d cycles expected %b for %0d",
                         e.name, cur_lamps, cur_len, e.lamps, e.dur);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            if (seg_valid) close_seg();
            seg_valid = 1'b0;
        end else if (!seg_valid) begin
            seg_valid = 1'b1;
            cur_lamps = lamps_now;
            cur_len   = 1;
        end else if (lamps_now !== cur_lamps) begin
            close_seg();
            cur_lamps = lamps_now;
            cur_len   = 1;
        end else begin
            cur_len++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ticks;
        int first_tick;
        bus.req      = '0;
        bus.actuated = 1'b0;
        bus.flash    = 1'b0;

        // Reset state
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_red", 32'(bus.red), 32'h7);
        chk("rst_green", 32'(bus.green), 32'h0);
        chk("rst_yellow", 32'(bus.yellow), 32'h0);
        chk("rst_phase", 32'(bus.active_phase), 32'h2);
        chk("rst_elapsed", 32'(bus.elapsed), 32'h0);
        chk("rst_pending", 32'(bus.pending), 32'h0);
        chk("rst_tick", 32'(bus.tick), 32'h0);

        // Fixed-time cycle through all phases
        push(LR, 4, "fx_r0");    push(lg(0), 20, "fx_g0"); push(ly(0), 8, "fx_y0");
        push(LR, 4, "fx_r1");    push(lg(1), 20, "fx_g1"); push(ly(1), 8, "fx_y1");
        push(LR, 4, "fx_r2");    push(lg(2), 20, "fx_g2"); push(ly(2), 8, "fx_y2");
        push(LR, 4, "fx_r3");
        @(posedge clk);
        #1 reset_n = 1'b1;
        ticks = 0;
        first_tick = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.tick) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
        end
        chk("first_tick", 32'(first_tick), 32'd3);
        chk("tick_count", 32'(ticks), 32'd10);

        // Actuated rest with no requests
        wait_for(ly(2), 100, "yellow2");
        bus.actuated = 1'b1;
        push(lg(0), 0, "act_g0_rest");
        wait_for(lg(0), 50, "green0_rest");
        repeat (110) @(negedge clk);
        chk("rest_lamps", 32'(lamps_now), 32'(lg(0)));
        chk("rest_elapsed_sat", 32'(bus.elapsed), 32'd15);

        // Skip: pending phase 2 bypasses phase 1
        push(ly(0), 8, "skip_y0"); push(LR, 4, "skip_r"); push(lg(2), 0, "skip_g2");
        bus.req = 3'b100;
        @(negedge clk);
        bus.req = 3'b000;
        chk("skip_pending", 32'(bus.pending), 32'h4);
        wait_for(lg(2), 60, "green2_skip");
        chk("skip_phase", 32'(bus.active_phase), 32'h2);
        chk("skip_pending_clr", 32'(bus.pending), 32'h0);

        // Extension: phase 0 request held keeps green to maximum
        push(ly(2), 8, "ext_y2"); push(LR, 4, "ext_r"); push(lg(0), 20, "ext_g0");
        push(ly(0), 8, "ext_y0"); push(LR, 4, "ext_r2"); push(lg(1), 0, "ext_g1");
        bus.req = 3'b011;
        @(negedge clk);
        bus.req = 3'b001;
        wait_for(lg(0), 60, "green0_ext");
        chk("ext_pending", 32'(bus.pending), 32'h2);
        wait_for(ly(0), 40, "yellow0_ext");
        bus.req = 3'b000;
        wait_for(lg(1), 30, "green1_ext");
        chk("ext_pending_clr", 32'(bus.pending), 32'h0);

        // Minimum green: phase 0 request released
        push(ly(1), 8, "min_y1"); push(LR, 4, "min_r"); push(lg(0), 8, "min_g0");
        push(ly(0), 8, "min_y0"); push(LR, 4, "min_r2"); push(lg(1), 4, "fl_g1");
        bus.req = 3'b001;
        @(negedge clk);
        bus.req = 3'b000;
        wait_for(ly(1), 40, "yellow1_min");
        bus.req = 3'b010;
        @(negedge clk);
        bus.req = 3'b000;
        wait_for(lg(0), 30, "green0_min");
        chk("min_pending", 32'(bus.pending), 32'h2);

        // Flash entry from the first cycle of green 1
        wait_for(lg(1), 40, "green1_flash");
        bus.flash = 1'b1;
        push(ly(1), 8, "fl_y1"); push(LR, 4, "fl_r"); push(LFON, 4, "fl_on1");
        push(LFOFF, 4, "fl_off1"); push(LFON, 4, "fl_on2");
        wait_for(LFOFF, 40, "flash_off1");
        repeat (8) @(negedge clk);
        chk("flash_off2_lamps", 32'(lamps_now), 32'(LFOFF));
        bus.flash = 1'b0;
        push(LFOFF, 4, "fl_off2"); push(LR, 4, "fl_exit_r"); push(lg(0), 0, "fl_exit_g0");
        wait_for(lg(0), 20, "green0_after_flash");
        chk("flash_exit_phase", 32'(bus.active_phase), 32'h0);

        // Asynchronous reset in the middle of yellow
        push(ly(0), 0, "rst_y0_cut");
        bus.req = 3'b010;
        @(negedge clk);
        bus.req = 3'b000;
        wait_for(ly(0), 30, "yellow0_rst");
        bus.req = 3'b100;
        @(negedge clk);
        bus.req = 3'b000;
        repeat (4) @(negedge clk);
        chk("pre_rst_pending", 32'(bus.pending), 32'h6);
        chk("pre_rst_elapsed", 32'(bus.elapsed), 32'h1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_red", 32'(bus.red), 32'h7);
        chk("arst_yellow", 32'(bus.yellow), 32'h0);
        chk("arst_pending", 32'(bus.pending), 32'h0);
        chk("arst_elapsed", 32'(bus.elapsed), 32'h0);
        chk("arst_phase", 32'(bus.active_phase), 32'h2);
        push(LR, 4, "rel_r"); push(lg(0), 0, "rel_g0"); push(ly(0), 8, "sim_y0");
        push(LR, 4, "sim_r");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        wait_for(lg(0), 20, "green0_after_rst");

        // Request held across the edge entering green 1 is cleared, not latched
        bus.req = 3'b010;
        wait_for(lg(1), 60, "green1_sim");
        chk("sim_phase", 32'(bus.active_phase), 32'h1);
        chk("sim_pending", 32'(bus.pending), 32'h0);
        repeat (3) @(negedge clk);
        chk("sim_pending_hold", 32'(bus.pending), 32'h0);
        bus.req = 3'b000;
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised N-phase traffic signal controller: the generalisation of the team's fixed two-road, fixed-time light to NUM_PHASES conflicting approaches. Adds actuated mode (request latching, phase skipping, min/max green with extension), a flash mode, and a tick divider that can be shrunk for simulation. It drives per-phase red/yellow/green lamp signals for the board's LED/7-segment emulation logic.

## Interface
- NUM_PHASES, 2: conflicting phases, 2..8
- TICK_DIV, 100_000_000: clock cycles per timing tick (1 s at 100 MHz), ≥2
- TIMER_W, 6: elapsed-tick counter width
- GREEN_MIN, 4: minimum green, ticks, ≥1
- GREEN_MAX, 8: maximum green, ticks, GREEN_MIN ≤ GREEN_MAX < 2^TIMER_W
- YELLOW_T, 2: yellow duration, ticks, ≥1
- ALLRED_T, 2: all-red clearance, ticks, ≥1
- PW, max(1,$clog2(NUM_PHASES)): phase index width (derived)

- CLK100MHZ  in  1  system clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_PHASES  per-phase service request, synchronous, already cleaned upstream
- actuated  in  1  1 = actuated mode, 0 = fixed-time
- flash  in  1  level request for flash mode
- green, yellow, red  out  NUM_PHASES each  lamp drives
- active_phase  out  PW  phase currently served
- elapsed  out  TIMER_W  whole ticks completed in current state
- pending  out  NUM_PHASES  latched requests
- tick  out  1  one-cycle timing tick

## Operation
- States: ALLRED, GREEN, YELLOW, FLASH. Lamps are Moore decodes of registered state/phase.
- ALLRED: red all 1. GREEN/YELLOW: green/yellow[active_phase]=1, red=1 on all other phases. FLASH: blink bit b drives yellow[0]=b, red[i]=b for i≠0, others 0.
- Reset values: state ALLRED, active_phase=NUM_PHASES-1, elapsed=0, prescaler=0, pending=0, blink=1; hence red=all 1, green=yellow=0, tick=0.
- Prescaler counts 0..TICK_DIV-1; tick = (count==TICK_DIV-1). On every state transition the prescaler and elapsed clear to 0.
- elapsed increments on tick, saturating at 2^TIMER_W-1. "Lasts D ticks" = transition on the tick where elapsed==D-1.
- pending[i] set when req[i]=1 and phase i is not currently in GREEN; cleared on the edge entering GREEN for phase i (clear wins over set).
- ALLRED: lasts ALLRED_T. Then FLASH if flash=1, otherwise GREEN of the next phase. Fixed: (active_phase+1) mod N. Actuated: first pending phase searching circularly from active_phase+1. If none is pending, use active_phase+1.
- GREEN, fixed mode: lasts GREEN_MAX.
- GREEN, actuated mode: let other = any pending[j], j≠active_phase. End on a tick when other=1 and either (elapsed ≥ GREEN_MIN-1 and req[active_phase]=0) or elapsed ≥ GREEN_MAX-1. With other=0 it rests indefinitely.
- GREEN with flash=1: ends on the next tick regardless of minimum.
- YELLOW: lasts YELLOW_T, then ALLRED. Never shortened.
- FLASH: blink toggles on every tick; entered with blink=1. On a tick with flash=0, go to ALLRED with active_phase=NUM_PHASES-1, so phase 0 is served next.
- actuated may change at any time; it is sampled only when GREEN-exit and next-phase decisions are made.
- Illegal state encoding → ALLRED on next edge.

## Timing
- State, lamps, elapsed, and active_phase update on the clock edge where tick=1 and the exit condition holds. New values are visible the following cycle.
- State of duration D occupies exactly D·TICK_DIV cycles.
- req latency into pending is 1 cycle. A 1-cycle req pulse is sufficient.
- reset_n assertion forces reset values immediately, including mid-state. The first tick after release is at cycle TICK_DIV-1.

## Test plan
Params: N=3, TICK_DIV=4, GREEN_MIN=2, GREEN_MAX=5, YELLOW_T=2, ALLRED_T=1, TIMER_W=4.
- Reset + fixed mode (actuated=0): after release, red=111 for 4 cycles. Then green=001 for 20 cycles, yellow=001 for 8, red=111 for 4, then green=010. Tick every 4 cycles.
- Actuated rest/skip: no req → green[0] holds ≥100 cycles, elapsed saturates at 15. Pulse req[2] 1 cycle (req[0]=0) → pending=100. Green ends at next tick, yellow 8, allred 4, green=100 (phase 1 skipped), pending=000.
- Extension: req[1] pending and req[0] held 1 → green[0] lasts 20 cycles. Repeat with req[0]=0 → 8 cycles.
- Flash: assert flash at first cycle of green[1] → green ends at its first tick. Yellow 8, allred 4, then FLASH: yellow[0]/red[1]/red[2] =1 for 4 cycles, 0 for 4, and so on. Deassert → allred 4 cycles → green=001.
- Async reset mid-yellow: drop reset_n between edges → red=111, pending=000, elapsed=0 without a clock edge.
- Simultaneous set/clear: req[1]=1 on the edge entering green[1] → pending[1]=0. req[1] during green[1] is not latched.
